order_book_top: RTL and testbench
=================================

Name: order_book_top

Overview:
- Producer side of the best-bid/best-ask interface consumed by the spread and analytics logic.
- Accepts single-unit limit orders over a valid/ready handshake.
- Matches each incoming order against the opposite side's best price, or rests it in a small per-side book.
- Publishes registered best_bid (00 = no bids) and best_ask (FF = no asks), and pulses match_valid on every trade.

Parameters:
- DEPTH, 8, resting entries per side; power of two, 2..16.
- IDX_W, 3, index width; must equal clog2(DEPTH).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- order_valid  in  1  order present
- order_ready  out  1  block can accept an order
- order_side  in  1  0 = buy, 1 = sell
- order_price  in  8  limit price
- best_bid  out  8  highest resting buy price; 00 when bid side is empty
- best_ask  out  8  lowest resting sell price; FF when ask side is empty
- match_valid  out  1  one-cycle pulse per trade
- match_price  out  8  resting order's price; valid with match_valid
- match_side  out  1  aggressor side; valid with match_valid
- order_reject  out  1  one-cycle pulse when an accepted order is dropped
- bid_count  out  IDX_W+1  number of resting bids
- ask_count  out  IDX_W+1  number of resting asks
- match_count  out  16  trade counter (see Optional Feature)

Behaviour:
- Reset values: all entry valid bits 0; best_bid 00; best_ask FF; bid_count 0; ask_count 0; match_valid 0; match_price 00; match_side 0; order_reject 0; match_count 0; order_ready 1; FSM in IDLE.
- FSM states: IDLE, EXEC, SCAN.
- IDLE:
  - order_ready = 1.
  - On order_valid && order_ready: latch side and price, go to EXEC.
- EXEC (order_ready = 0), decisions use the registered best_* values:
  - Illegal price (buy with 00, sell with FF): pulse order_reject next cycle, go to IDLE. Book unchanged, no scan.
  - Buy with ask side non-empty and price >= best_ask: trade. Clear the entry at best_ask_idx; match_price = best_ask; match_side = 0.
  - Sell with bid side non-empty and price <= best_bid: trade. Clear the entry at best_bid_idx; match_price = best_bid; match_side = 1.
  - On a trade: match_valid pulses next cycle and the opposite count decrements. The incoming order is fully consumed and does not rest.
  - No trade, free slot on own side: write the order into the lowest-index free slot and increment the own count.
  - No trade, own side full: pulse order_reject; book unchanged; go to IDLE.
  - After a trade or an insert: go to SCAN with index 0.
- SCAN (order_ready = 0):
  - Runs exactly DEPTH cycles, visiting entry i of both sides per cycle.
  - Tracks running max bid and min ask using strict compare, so on ties the lowest index wins. Indices are recorded.
  - On the edge ending the last scan cycle: update best_bid, best_ask, best_bid_idx and best_ask_idx, then go to IDLE.
  - An empty side yields 00 (bids) or FF (asks).
- Latency:
  - Handshake at cycle t; trade or reject pulse visible at t+2.
  - For trade or insert: best_* updated and order_ready high at t+2+DEPTH.
  - For reject: order_ready high at t+2.
- Pulses last exactly one cycle. match_price and match_side hold their last value between trades.
- Reset mid-operation (any state): all state returns to reset values immediately. Any in-flight order is discarded with no pulse.
- order_valid while order_ready = 0 is ignored; the sender must hold the order until the handshake completes.

Optional Feature:
- Macro: ORDER_BOOK_MATCH_COUNT_EN.
- Defined: match_count increments by 1 in the cycle match_valid is high and saturates at FFFF. Cleared only by reset.
- Undefined: match_count is tied to 0000 and no counter logic is built. The port is present in both builds.

Test Plan:
- Reset, then release -> best_bid 00, best_ask FF, counts 0, order_ready 1, no pulses.
- Buy 40, then sell 50 -> no match_valid. order_ready low for DEPTH+1 cycles after each handshake. Afterwards best_bid 40, best_ask 50, bid_count 1, ask_count 1.
- Continue with sell 3C -> match_valid pulse at t+2 with match_price 40, match_side 1. After the scan: best_bid 00, bid_count 0, ask_count 1, match_count 1 when the macro is defined.
- Buys 10..17 (8 orders), then buy 05 -> 9th order gives order_reject at t+2 and order_ready high at t+2. bid_count stays 8, best_bid 17.
- Buy 00 and sell FF -> each gives an order_reject pulse; counts and best_* unchanged.
- Rest buy 30, start sell 60, assert reset during SCAN -> all outputs at reset values. Book empty: a later buy FF produces no match.

Source files
------------

// File: rtl/order_book_top.sv
// Single-unit limit order book: matches against the opposite best price or rests the order,
// then rescans both sides to refresh best_bid/best_ask. Optional macro: ORDER_BOOK_MATCH_COUNT_EN.
module order_book_top #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             order_valid,
    output logic             order_ready,
    input  logic             order_side,
    input  logic [7:0]       order_price,
    output logic [7:0]       best_bid,
    output logic [7:0]       best_ask,
    output logic             match_valid,
    output logic [7:0]       match_price,
    output logic             match_side,
    output logic             order_reject,
    output logic [IDX_W:0]   bid_count,
    output logic [IDX_W:0]   ask_count,
    output logic [15:0]      match_count
);

    typedef enum logic [1:0] {StIdle, StExec, StScan} state_e;

    state_e state_q, state_d;

    logic             ord_side_q;
    logic [7:0]       ord_price_q;
    logic [DEPTH-1:0] bid_vld_q, ask_vld_q;
    logic [7:0]       bid_px_q [DEPTH];
    logic [7:0]       ask_px_q [DEPTH];
    logic [IDX_W-1:0] best_bid_idx_q, best_ask_idx_q;
    logic [IDX_W-1:0] scan_idx_q;
    logic [7:0]       run_bid_q, run_ask_q;
    logic [IDX_W-1:0] run_bid_idx_q, run_ask_idx_q;

    logic             illegal, trade, own_full, reject, scan_last;
    logic [IDX_W-1:0] free_idx;
    logic [DEPTH-1:0] own_vld;
    logic [7:0]       nxt_bid, nxt_ask;
    logic [IDX_W-1:0] nxt_bid_idx, nxt_ask_idx;

    always_comb begin
        illegal  = ord_side_q ? (ord_price_q == 8'hFF) : (ord_price_q == 8'h00);
        trade    = 1'b0;
        if (!illegal) begin
            if (!ord_side_q) trade = (ask_count != '0) && (ord_price_q >= best_ask);
            else             trade = (bid_count != '0) && (ord_price_q <= best_bid);
        end
        own_full = ord_side_q ? (ask_count == (IDX_W+1)'(DEPTH))
                              : (bid_count == (IDX_W+1)'(DEPTH));
        reject   = illegal || (!trade && own_full);
        own_vld  = ord_side_q ? ask_vld_q : bid_vld_q;
        free_idx = '0;
        // Descending walk so the lowest free index is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!own_vld[i]) free_idx = IDX_W'(i);
        end
    end

    // Strict compares keep the lowest index on equal prices.
    always_comb begin
        nxt_bid     = run_bid_q;
        nxt_bid_idx = run_bid_idx_q;
        nxt_ask     = run_ask_q;
        nxt_ask_idx = run_ask_idx_q;
        if (bid_vld_q[scan_idx_q] && (bid_px_q[scan_idx_q] > run_bid_q)) begin
            nxt_bid     = bid_px_q[scan_idx_q];
            nxt_bid_idx = scan_idx_q;
        end
        if (ask_vld_q[scan_idx_q] && (ask_px_q[scan_idx_q] < run_ask_q)) begin
            nxt_ask     = ask_px_q[scan_idx_q];
            nxt_ask_idx = scan_idx_q;
        end
        scan_last = (scan_idx_q == IDX_W'(DEPTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (order_valid) state_d = StExec;
            StExec:  state_d = reject ? StIdle : StScan;
            StScan:  if (scan_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        order_ready = (state_q == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ord_side_q     <= 1'b0;
            ord_price_q    <= 8'h00;
            bid_vld_q      <= '0;
            ask_vld_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bid_px_q[i] <= 8'h00;
                ask_px_q[i] <= 8'h00;
            end
            best_bid       <= 8'h00;
            best_ask       <= 8'hFF;
            best_bid_idx_q <= '0;
            best_ask_idx_q <= '0;
            scan_idx_q     <= '0;
            run_bid_q      <= 8'h00;
            run_ask_q      <= 8'hFF;
            run_bid_idx_q  <= '0;
            run_ask_idx_q  <= '0;
            bid_count      <= '0;
            ask_count      <= '0;
            match_valid    <= 1'b0;
            match_price    <= 8'h00;
            match_side     <= 1'b0;
            order_reject   <= 1'b0;
        end else begin
            match_valid  <= 1'b0;
            order_reject <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (order_valid) begin
                        ord_side_q  <= order_side;
                        ord_price_q <= order_price;
                    end
                end
                StExec: begin
                    if (reject) begin
                        order_reject <= 1'b1;
                    end else begin
                        if (trade) begin
                            match_valid <= 1'b1;
                            match_side  <= ord_side_q;
                            if (!ord_side_q) begin
                                ask_vld_q[best_ask_idx_q] <= 1'b0;
                                ask_count                 <= ask_count - 1'b1;
                                match_price               <= best_ask;
                            end else begin
                                bid_vld_q[best_bid_idx_q] <= 1'b0;
                                bid_count                 <= bid_count - 1'b1;
                                match_price               <= best_bid;
                            end
                        end else if (!ord_side_q) begin
                            bid_vld_q[free_idx] <= 1'b1;
                            bid_px_q[free_idx]  <= ord_price_q;
                            bid_count           <= bid_count + 1'b1;
                        end else begin
                            ask_vld_q[free_idx] <= 1'b1;
                            ask_px_q[free_idx]  <= ord_price_q;
                            ask_count           <= ask_count + 1'b1;
                        end
                        scan_idx_q    <= '0;
                        run_bid_q     <= 8'h00;
                        run_ask_q     <= 8'hFF;
                        run_bid_idx_q <= '0;
                        run_ask_idx_q <= '0;
                    end
                end
                StScan: begin
                    run_bid_q     <= nxt_bid;
                    run_ask_q     <= nxt_ask;
                    run_bid_idx_q <= nxt_bid_idx;
                    run_ask_idx_q <= nxt_ask_idx;
                    scan_idx_q    <= scan_idx_q + 1'b1;
                    if (scan_last) begin
                        best_bid       <= nxt_bid;
                        best_ask       <= nxt_ask;
                        best_bid_idx_q <= nxt_bid_idx;
                        best_ask_idx_q <= nxt_ask_idx;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ORDER_BOOK_MATCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   match_count <= 16'h0000;
        else if (match_valid && match_count != 16'hFFFF) match_count <= match_count + 16'h0001;
    end
`else
    assign match_count = 16'h0000;
`endif

endmodule

// File: tb/tb_order_book_top.sv
// Bench for order_book_top: directed scenarios then random orders, checked against a
// price-multiset model of both book sides.
module tb_order_book_top;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           order_valid = 1'b0;
    logic           order_ready;
    logic           order_side = 1'b0;
    logic [7:0]     order_price = 8'h00;
    logic [7:0]     best_bid, best_ask, match_price;
    logic           match_valid, match_side, order_reject;
    logic [IDX_W:0] bid_count, ask_count;
    logic [15:0]    match_count;

    int checks = 0;
    int errors = 0;
    int bids[$];
    int asks[$];
    int mcount = 0;

    order_book_top #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .order_valid(order_valid), .order_ready(order_ready),
        .order_side(order_side), .order_price(order_price), .best_bid(best_bid),
        .best_ask(best_ask), .match_valid(match_valid), .match_price(match_price),
        .match_side(match_side), .order_reject(order_reject), .bid_count(bid_count),
        .ask_count(ask_count), .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_bid();
        int m = 0;
        foreach (bids[i]) if (bids[i] > m) m = bids[i];
        return m;
    endfunction

    function automatic int model_ask();
        int m = 255;
        foreach (asks[i]) if (asks[i] < m) m = asks[i];
        return m;
    endfunction

    function automatic int exp_mcount();
`ifdef ORDER_BOOK_MATCH_COUNT_EN
        return (mcount > 65535) ? 65535 : mcount;
`else
        return 0;
`endif
    endfunction

    task automatic check_book(input string tag);
        check({tag, ".best_bid"}, 32'(best_bid), 32'(model_bid()));
        check({tag, ".best_ask"}, 32'(best_ask), 32'(model_ask()));
        check({tag, ".bid_count"}, 32'(bid_count), 32'(bids.size()));
        check({tag, ".ask_count"}, 32'(ask_count), 32'(asks.size()));
        check({tag, ".match_count"}, 32'(match_count), 32'(exp_mcount()));
    endtask

    task automatic check_reset_state();
        check("rst.best_bid", 32'(best_bid), 32'h00);
        check("rst.best_ask", 32'(best_ask), 32'hFF);
        check("rst.bid_count", 32'(bid_count), 0);
        check("rst.ask_count", 32'(ask_count), 0);
        check("rst.order_ready", 32'(order_ready), 1);
        check("rst.match_valid", 32'(match_valid), 0);
        check("rst.order_reject", 32'(order_reject), 0);
        check("rst.match_price", 32'(match_price), 0);
        check("rst.match_side", 32'(match_side), 0);
        check("rst.match_count", 32'(match_count), 0);
    endtask

    task automatic send_order(input bit side, input logic [7:0] price, input string tag);
        int  bb, ba, n;
        bit  exp_rej, exp_trade, stray;
        int  exp_mp;
        bb = model_bid();
        ba = model_ask();
        exp_trade = 1'b0;
        exp_mp = 0;
        if (!side && price == 8'h00) exp_rej = 1'b1;
        else if (side && price == 8'hFF) exp_rej = 1'b1;
        else begin
            exp_rej = 1'b0;
            if (!side && asks.size() > 0 && int'(price) >= ba) begin
                exp_trade = 1'b1; exp_mp = ba;
            end else if (side && bids.size() > 0 && int'(price) <= bb) begin
                exp_trade = 1'b1; exp_mp = bb;
            end else if (!side && bids.size() == DEPTH) exp_rej = 1'b1;
            else if (side && asks.size() == DEPTH) exp_rej = 1'b1;
        end

        n = 0;
        while (!order_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, ".ready_wait"}, 32'(order_ready), 1);

        @(negedge clk);
        order_valid = 1'b1;
        order_side  = side;
        order_price = price;
        @(posedge clk); #1;
        order_valid = 1'b0;

        stray = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                check({tag, ".match_valid"}, 32'(match_valid), 32'(exp_trade));
                check({tag, ".order_reject"}, 32'(order_reject), 32'(exp_rej));
                if (exp_trade) begin
                    check({tag, ".match_price"}, 32'(match_price), 32'(exp_mp));
                    check({tag, ".match_side"}, 32'(match_side), 32'(side));
                end
            end else if (match_valid || order_reject) stray = 1'b1;
            if (order_ready) break;
        end
        check({tag, ".latency"}, 32'(n), exp_rej ? 32'd1 : 32'(DEPTH + 1));
        check({tag, ".stray_pulse"}, 32'(stray), 0);

        if (exp_trade) begin
            mcount++;
            if (!side) begin
                foreach (asks[i]) if (asks[i] == ba) begin asks.delete(i); break; end
            end else begin
                foreach (bids[i]) if (bids[i] == bb) begin bids.delete(i); break; end
            end
        end else if (!exp_rej) begin
            if (!side) bids.push_back(int'(price));
            else       asks.push_back(int'(price));
        end
        @(posedge clk); #1;
        check_book(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_reset_state();
        bids.delete();
        asks.delete();
        mcount = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] p;
        bit         s;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_state();

        send_order(1'b0, 8'h40, "buy40");
        send_order(1'b1, 8'h50, "sell50");
        send_order(1'b1, 8'h3C, "sell3C_trade");

        for (int i = 0; i < 8; i++) send_order(1'b0, 8'(8'h10 + i), "fill_bids");
        send_order(1'b0, 8'h05, "bid_full");
        send_order(1'b0, 8'h00, "buy00");
        send_order(1'b1, 8'hFF, "sellFF");

        @(negedge clk);
        apply_reset();
        send_order(1'b0, 8'h30, "buy30");
        @(negedge clk);
        order_valid = 1'b1; order_side = 1'b1; order_price = 8'h60;
        @(posedge clk); #1;
        order_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        apply_reset();
        send_order(1'b0, 8'hFF, "post_reset_buyFF");

        for (int k = 0; k < 200; k++) begin
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) p = s ? 8'hFF : 8'h00;
            else p = 8'($urandom_range(8'h38, 8'h48));
            send_order(s, p, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
